fifo2axi_arb_mux: RTL and testbench

- N-channel, packet-aware successor to the two-channel command/write FIFO mux feeding the AXI write master.
- Arbitrates NUM_CH producers onto one command FIFO and one write-data FIFO.
- Switches channels only at burst boundaries: one command plus LEN+1 data beats.
- Mode is either round-robin or externally forced channel select.

---
 rtl/fifo2axi_arb_mux.sv | 188 ++++++++++++++++++
 tb/tb_fifo2axi_arb_mux.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo2axi_arb_mux.sv
// N-channel burst-aware arbiter feeding one command FIFO and one write-data FIFO.
// Define FIFO2AXI_ARB_STATS_EN to add per-channel burst and dropped-strobe counters.
module fifo2axi_arb_mux #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CMD_W   = 64,
    parameter int unsigned DAT_W   = 128,
    parameter int unsigned LEN_LSB = 0,
    parameter int unsigned LEN_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sel_mode,
    input  logic [2:0]              sel_ch,
    input  logic [NUM_CH-1:0]       ch_req,
    input  logic [NUM_CH*CMD_W-1:0] ch_cmd_din,
    input  logic [NUM_CH-1:0]       ch_cmd_wr_en,
    output logic [NUM_CH-1:0]       ch_cmd_full,
    input  logic [NUM_CH*DAT_W-1:0] ch_wr_din,
    input  logic [NUM_CH-1:0]       ch_wr_wr_en,
    output logic [NUM_CH-1:0]       ch_wr_full,
    output logic [CMD_W-1:0]        fifo_din_cmd_o,
    output logic                    fifo_wr_en_cmd_o,
    input  logic                    fifo_full_cmd_i,
    output logic [DAT_W-1:0]        fifo_din_wr_o,
    output logic                    fifo_wr_en_wr_o,
    input  logic                    fifo_full_wr_i,
    output logic [NUM_CH-1:0]       grant_o,
    output logic                    busy_o
`ifdef FIFO2AXI_ARB_STATS_EN
    ,
    output logic [NUM_CH*32-1:0]    stat_pkt_cnt,
    output logic [31:0]             stat_drop_cnt
`endif
);

    localparam int unsigned IdxW = $clog2(NUM_CH);

    typedef enum logic [1:0] {StIdle, StGntCmd, StGntDat} state_e;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]  gnt_idx_q, gnt_idx_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CMD_W-1:0] din_cmd_q, din_cmd_d;
    logic [DAT_W-1:0] din_wr_q, din_wr_d;
    logic             we_cmd_q, we_cmd_d;
    logic             we_wr_q, we_wr_d;

    logic             pick_vld;
    logic [IdxW-1:0]  pick_idx;
    logic [CMD_W-1:0] sel_cmd;
    logic [DAT_W-1:0] sel_dat;
    logic             cmd_acc;
    logic             dat_acc;

    assign sel_cmd = ch_cmd_din[32'(gnt_idx_q)*CMD_W +: CMD_W];
    assign sel_dat = ch_wr_din[32'(gnt_idx_q)*DAT_W +: DAT_W];
    assign cmd_acc = (state_q == StGntCmd) && ch_cmd_wr_en[gnt_idx_q] && !fifo_full_cmd_i;
    assign dat_acc = (state_q == StGntDat) && ch_wr_wr_en[gnt_idx_q] && !fifo_full_wr_i;

    // Forced select ignores out-of-range sel_ch; round-robin searches from rr_ptr+1 with wrap.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        if (sel_mode) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (32'(sel_ch) == i && ch_req[i]) begin
                    pick_vld = 1'b1;
                    pick_idx = IdxW'(i);
                end
            end
        end else begin
            for (int unsigned k = 1; k <= NUM_CH; k++) begin
                if (!pick_vld && ch_req[(32'(rr_ptr_q) + k) % NUM_CH]) begin
                    pick_vld = 1'b1;
                    pick_idx = IdxW'((32'(rr_ptr_q) + k) % NUM_CH);
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_idx_d  = gnt_idx_q;
        beat_cnt_d = beat_cnt_q;
        din_cmd_d  = din_cmd_q;
        din_wr_d   = din_wr_q;
        we_cmd_d   = 1'b0;
        we_wr_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    gnt_idx_d = pick_idx;
                    if (!sel_mode) rr_ptr_d = pick_idx;
                    state_d = StGntCmd;
                end
            end
            StGntCmd: begin
                if (cmd_acc) begin
                    din_cmd_d  = sel_cmd;
                    we_cmd_d   = 1'b1;
                    beat_cnt_d = sel_cmd[LEN_LSB +: LEN_W];
                    state_d    = StGntDat;
                end
            end
            StGntDat: begin
                if (dat_acc) begin
                    din_wr_d = sel_dat;
                    we_wr_d  = 1'b1;
                    if (beat_cnt_q == '0) state_d = StIdle;
                    else                  beat_cnt_d = beat_cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            rr_ptr_q   <= IdxW'(NUM_CH - 1);
            gnt_idx_q  <= '0;
            beat_cnt_q <= '0;
            din_cmd_q  <= '0;
            din_wr_q   <= '0;
            we_cmd_q   <= 1'b0;
            we_wr_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_idx_q  <= gnt_idx_d;
            beat_cnt_q <= beat_cnt_d;
            din_cmd_q  <= din_cmd_d;
            din_wr_q   <= din_wr_d;
            we_cmd_q   <= we_cmd_d;
            we_wr_q    <= we_wr_d;
        end
    end

    // Only the granted channel in the matching phase sees the downstream prog_full.
    always_comb begin
        ch_cmd_full = '1;
        ch_wr_full  = '1;
        grant_o     = '0;
        if (state_q == StGntCmd) ch_cmd_full[gnt_idx_q] = fifo_full_cmd_i;
        if (state_q == StGntDat) ch_wr_full[gnt_idx_q] = fifo_full_wr_i;
        if (state_q != StIdle)   grant_o[gnt_idx_q] = 1'b1;
    end

    assign busy_o           = (state_q != StIdle);
    assign fifo_din_cmd_o   = din_cmd_q;
    assign fifo_wr_en_cmd_o = we_cmd_q;
    assign fifo_din_wr_o    = din_wr_q;
    assign fifo_wr_en_wr_o  = we_wr_q;

`ifdef FIFO2AXI_ARB_STATS_EN
    logic [NUM_CH*32-1:0] pkt_cnt_q;
    logic [31:0]          drop_cnt_q;
    logic [32:0]          drop_sum;

    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            drop_sum = drop_sum + 33'(ch_cmd_wr_en[i] & ch_cmd_full[i])
                                + 33'(ch_wr_wr_en[i] & ch_wr_full[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
            if (dat_acc && beat_cnt_q == '0) begin
                pkt_cnt_q[32'(gnt_idx_q)*32 +: 32] <= pkt_cnt_q[32'(gnt_idx_q)*32 +: 32] + 32'd1;
            end
        end
    end

    assign stat_pkt_cnt  = pkt_cnt_q;
    assign stat_drop_cnt = drop_cnt_q;
`else
    // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_fifo2axi_arb_mux.sv
// Self-checking bench for fifo2axi_arb_mux: directed arbitration table, burst corner
// sequences, then randomized traffic against a transaction-level reference model.
module tb_fifo2axi_arb_mux;

    localparam int NUM_CH  = 4;
    localparam int CMD_W   = 64;
    localparam int DAT_W   = 128;
    localparam int LEN_LSB = 0;
    localparam int LEN_W   = 8;
    localparam logic [NUM_CH-1:0] ALL1 = '1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    sel_mode = 1'b0;
    logic [2:0]              sel_ch = '0;
    logic [NUM_CH-1:0]       ch_req = '0;
    logic [NUM_CH*CMD_W-1:0] ch_cmd_din = '0;
    logic [NUM_CH-1:0]       ch_cmd_wr_en = '0;
    logic [NUM_CH-1:0]       ch_cmd_full;
    logic [NUM_CH*DAT_W-1:0] ch_wr_din = '0;
    logic [NUM_CH-1:0]       ch_wr_wr_en = '0;
    logic [NUM_CH-1:0]       ch_wr_full;
    logic [CMD_W-1:0]        fifo_din_cmd_o;
    logic                    fifo_wr_en_cmd_o;
    logic                    fifo_full_cmd_i = 1'b0;
    logic [DAT_W-1:0]        fifo_din_wr_o;
    logic                    fifo_wr_en_wr_o;
    logic                    fifo_full_wr_i = 1'b0;
    logic [NUM_CH-1:0]       grant_o;
    logic                    busy_o;

    int n_chk  = 0;
    int n_pass = 0;

    fifo2axi_arb_mux #(
        .NUM_CH (NUM_CH),
        .CMD_W  (CMD_W),
        .DAT_W  (DAT_W),
        .LEN_LSB(LEN_LSB),
        .LEN_W  (LEN_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sel_mode        (sel_mode),
        .sel_ch          (sel_ch),
        .ch_req          (ch_req),
        .ch_cmd_din      (ch_cmd_din),
        .ch_cmd_wr_en    (ch_cmd_wr_en),
        .ch_cmd_full     (ch_cmd_full),
        .ch_wr_din       (ch_wr_din),
        .ch_wr_wr_en     (ch_wr_wr_en),
        .ch_wr_full      (ch_wr_full),
        .fifo_din_cmd_o  (fifo_din_cmd_o),
        .fifo_wr_en_cmd_o(fifo_wr_en_cmd_o),
        .fifo_full_cmd_i (fifo_full_cmd_i),
        .fifo_din_wr_o   (fifo_din_wr_o),
        .fifo_wr_en_wr_o (fifo_wr_en_wr_o),
        .fifo_full_wr_i  (fifo_full_wr_i),
        .grant_o         (grant_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic clear_inputs();
        ch_req = '0;
        ch_cmd_wr_en = '0;
        ch_wr_wr_en = '0;
        fifo_full_cmd_i = 1'b0;
        fifo_full_wr_i = 1'b0;
        sel_mode = 1'b0;
        sel_ch = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " grant"}, grant_o, 0);
        chk({tag, " busy"}, busy_o, 0);
        chk({tag, " cmd_we"}, fifo_wr_en_cmd_o, 0);
        chk({tag, " wr_we"}, fifo_wr_en_wr_o, 0);
        chk({tag, " cmd_din"}, fifo_din_cmd_o, 0);
        chk({tag, " wr_din"}, fifo_din_wr_o, 0);
        chk({tag, " cmd_full"}, ch_cmd_full, ALL1);
        chk({tag, " wr_full"}, ch_wr_full, ALL1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset cmd_full", ch_cmd_full, ALL1);
        chk("post-reset wr_full", ch_wr_full, ALL1);
    endtask

    // Runs one burst from IDLE; called at a negedge, returns at the negedge of the dead cycle.
    task automatic burst(input bit mode, input int sel, input logic [NUM_CH-1:0] req,
                         input int exp_ch, input int len, input int stall_at,
                         input int abort_at, input int new_sel);
        logic [NUM_CH-1:0] oh;
        logic [NUM_CH-1:0] noh;
        logic [CMD_W-1:0]  cmd;
        logic [DAT_W-1:0]  w;
        int                b;
        int                stall_left;
        bit                st;
        sel_mode = mode;
        sel_ch   = 3'(sel);
        ch_req   = req;
        @(negedge clk);
        oh = '0;
        if (exp_ch >= 0) oh[exp_ch] = 1'b1;
        noh = ~oh;
        chk("grant", grant_o, oh);
        chk("busy", busy_o, exp_ch >= 0);
        if (exp_ch < 0) return;
        for (int i = 0; i < NUM_CH; i++) ch_cmd_din[i*CMD_W +: CMD_W] = {$urandom, $urandom};
        cmd = {$urandom, $urandom};
        cmd[LEN_LSB +: LEN_W] = LEN_W'(len);
        ch_cmd_din[exp_ch*CMD_W +: CMD_W] = cmd;
        ch_cmd_wr_en = oh;
        ch_cmd_wr_en[(exp_ch + 1) % NUM_CH] = 1'b1;
        ch_wr_wr_en = oh;
        #1;
        chk("cmd phase cmd_full", ch_cmd_full, noh);
        chk("cmd phase wr_full", ch_wr_full, ALL1);
        @(negedge clk);
        ch_cmd_wr_en = oh;
        chk("cmd_we", fifo_wr_en_cmd_o, 1);
        chk("cmd_din", fifo_din_cmd_o, cmd);
        chk("no data during cmd", fifo_wr_en_wr_o, 0);
        if (new_sel >= 0) sel_ch = 3'(new_sel);
        b = 0;
        stall_left = 5;
        while (b <= len) begin
            if (b == abort_at) begin
                rst = 1'b1;
                #1;
                check_reset_outputs("abort");
                clear_inputs();
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            st = (b == stall_at) && (stall_left > 0);
            fifo_full_wr_i = st;
            w = rand128();
            for (int i = 0; i < NUM_CH; i++) ch_wr_din[i*DAT_W +: DAT_W] = rand128();
            ch_wr_din[exp_ch*DAT_W +: DAT_W] = w;
            ch_wr_wr_en = oh;
            #1;
            chk("data wr_full", ch_wr_full, st ? ALL1 : noh);
            chk("data cmd_full", ch_cmd_full, ALL1);
            chk("grant held", grant_o, oh);
            @(negedge clk);
            chk("wr_we", fifo_wr_en_wr_o, !st);
            if (!st) chk("wr_din", fifo_din_wr_o, w);
            chk("no cmd during data", fifo_wr_en_cmd_o, 0);
            if (st) stall_left--;
            else    b++;
        end
        ch_wr_wr_en = '0;
        ch_cmd_wr_en = '0;
        fifo_full_wr_i = 1'b0;
        chk("dead cycle grant", grant_o, 0);
        chk("dead cycle busy", busy_o, 0);
    endtask

    // Transaction-level model: producers hold bursts, the arbiter hands one whole burst at a time.
    task automatic random_phase(input int cycles);
        int                rr;
        int                cur;
        int                beats_left;
        int                pick;
        int                s;
        bit                cmd_done;
        bit                pc;
        bit                pd;
        bit                drain;
        bit                any_have;
        logic [CMD_W-1:0]  pcw;
        logic [CMD_W-1:0]  cur_cmd;
        logic [DAT_W-1:0]  pdw;
        bit                have[NUM_CH];
        int                blen[NUM_CH];
        logic [CMD_W-1:0]  bcmd[NUM_CH];
        logic [NUM_CH-1:0] oh;
        logic [NUM_CH-1:0] ecf;
        logic [NUM_CH-1:0] ewf;
        rr = NUM_CH - 1;
        cur = -1;
        beats_left = 0;
        cmd_done = 1'b0;
        pc = 1'b0;
        pd = 1'b0;
        pcw = '0;
        pdw = '0;
        cur_cmd = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            have[i] = 1'b0;
            blen[i] = 0;
            bcmd[i] = '0;
        end
        for (int cyc = 0; cyc < cycles + 3000; cyc++) begin
            drain = (cyc >= cycles);
            chk("rnd cmd_we", fifo_wr_en_cmd_o, pc);
            if (pc) chk("rnd cmd_din", fifo_din_cmd_o, pcw);
            chk("rnd wr_we", fifo_wr_en_wr_o, pd);
            if (pd) chk("rnd wr_din", fifo_din_wr_o, pdw);
            oh = '0;
            if (cur >= 0) oh[cur] = 1'b1;
            chk("rnd grant", grant_o, oh);
            chk("rnd busy", busy_o, cur >= 0);
            any_have = 1'b0;
            for (int i = 0; i < NUM_CH; i++) any_have |= have[i];
            if (drain && cur < 0 && !any_have) break;
            fifo_full_cmd_i = ($urandom_range(0, 3) == 0);
            fifo_full_wr_i  = ($urandom_range(0, 3) == 0);
            #1;
            ecf = ALL1;
            ewf = ALL1;
            if (cur >= 0 && !cmd_done) ecf[cur] = fifo_full_cmd_i;
            if (cur >= 0 && cmd_done)  ewf[cur] = fifo_full_wr_i;
            chk("rnd cmd_full", ch_cmd_full, ecf);
            chk("rnd wr_full", ch_wr_full, ewf);
            for (int i = 0; i < NUM_CH; i++) begin
                if (!drain && !have[i] && $urandom_range(0, 5) == 0) begin
                    have[i] = 1'b1;
                    blen[i] = ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 5));
                    bcmd[i] = {$urandom, $urandom};
                    bcmd[i][LEN_LSB +: LEN_W] = LEN_W'(blen[i]);
                end
                ch_req[i] = have[i];
                ch_cmd_wr_en[i] = 1'($urandom_range(0, 1));
                ch_wr_wr_en[i] = 1'($urandom_range(0, 1));
                ch_cmd_din[i*CMD_W +: CMD_W] = {$urandom, $urandom};
                ch_wr_din[i*DAT_W +: DAT_W] = rand128();
            end
            if (cur >= 0 && !cmd_done) ch_cmd_din[cur*CMD_W +: CMD_W] = cur_cmd;
            if (drain) sel_mode = 1'b0;
            else if ($urandom_range(0, 39) == 0) sel_mode = 1'($urandom_range(0, 1));
            if (sel_mode && $urandom_range(0, 3) == 0) sel_ch = 3'($urandom_range(0, 7));
            pc = 1'b0;
            pd = 1'b0;
            if (cur < 0) begin
                pick = -1;
                s = int'(sel_ch);
                if (sel_mode) begin
                    if (s < NUM_CH && have[s]) pick = s;
                end else begin
                    for (int k = 1; k <= NUM_CH; k++) begin
                        if (pick < 0 && have[(rr + k) % NUM_CH]) pick = (rr + k) % NUM_CH;
                    end
                end
                if (pick >= 0) begin
                    if (!sel_mode) rr = pick;
                    cur = pick;
                    cmd_done = 1'b0;
                    cur_cmd = bcmd[pick];
                    beats_left = blen[pick] + 1;
                    have[pick] = 1'b0;
                end
            end else if (!cmd_done) begin
                if (ch_cmd_wr_en[cur] && !fifo_full_cmd_i) begin
                    pc = 1'b1;
                    pcw = cur_cmd;
                    cmd_done = 1'b1;
                end
            end else if (ch_wr_wr_en[cur] && !fifo_full_wr_i) begin
                pd = 1'b1;
                pdw = ch_wr_din[cur*DAT_W +: DAT_W];
                beats_left--;
                if (beats_left == 0) cur = -1;
            end
            @(negedge clk);
        end
        chk("rnd drained", cur < 0, 1);
        clear_inputs();
    endtask

    typedef struct {
        bit                mode;
        int                sel;
        logic [NUM_CH-1:0] req;
        int                len;
        int                exp_ch;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // Arbitration table applied back-to-back from reset (rr pointer starts at NUM_CH-1).
        tbl[0]  = '{1'b0, 0, 4'b1111, 3, 0};
        tbl[1]  = '{1'b0, 0, 4'b1111, 3, 1};
        tbl[2]  = '{1'b0, 0, 4'b1111, 3, 2};
        tbl[3]  = '{1'b0, 0, 4'b1111, 3, 3};
        tbl[4]  = '{1'b0, 0, 4'b1111, 3, 0};
        tbl[5]  = '{1'b0, 0, 4'b1001, 0, 3};
        tbl[6]  = '{1'b0, 0, 4'b1001, 0, 0};
        tbl[7]  = '{1'b1, 2, 4'b0101, 1, 2};
        tbl[8]  = '{1'b1, 1, 4'b0101, 0, -1};
        tbl[9]  = '{1'b1, 5, 4'b1111, 0, -1};
        tbl[10] = '{1'b0, 0, 4'b0100, 0, 2};
        tbl[11] = '{1'b0, 0, 4'b0000, 0, -1};
        tbl[12] = '{1'b0, 0, 4'b0010, 2, 1};

        #1 rst = 1'b1;
        #2;
        check_reset_outputs("initial reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle cmd_full", ch_cmd_full, ALL1);
        chk("idle wr_full", ch_wr_full, ALL1);
        chk("idle grant", grant_o, 0);

        for (int i = 0; i < 13; i++) begin
            burst(tbl[i].mode, tbl[i].sel, tbl[i].req, tbl[i].exp_ch, tbl[i].len, -1, -1, -1);
        end

        // Forced select: sel_ch moves to 0 mid-burst, ch2 still finishes first.
        burst(1'b1, 2, 4'b0101, 2, 3, -1, -1, 0);
        burst(1'b1, 0, 4'b0101, 0, 0, -1, -1, -1);
        // Backpressure on data for 5 cycles in the middle of an 8-beat burst (rr still at 1).
        burst(1'b0, 0, 4'b1000, 3, 7, 3, -1, -1);
        // Maximum length: 256 beats.
        burst(1'b0, 0, 4'b0001, 0, 255, -1, -1, -1);
        // Reset at beat 3 of 8, then round-robin restarts at ch0.
        burst(1'b0, 0, 4'b0100, 2, 7, -1, 3, -1);
        burst(1'b0, 0, 4'b1111, 0, 1, -1, -1, -1);

        do_reset();
        random_phase(3000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
